// File: rtl/fft_bitrev_mover.sv
// rtl/fft_bitrev_mover.sv - block mover copying 2N interleaved complex words, optionally in bit-reversed point order
module fft_bitrev_mover #(
   parameter int MDATAW = 8,
   parameter int DATAW  = 16,
   parameter int FFTSIZ = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rev,
   input  logic [MDATAW-1:0] src,
   input  logic [MDATAW-1:0] dst,
   output logic              rd_en,
   output logic [MDATAW-1:0] rd_addr,
   input  logic [DATAW-1:0]  rd_data,
   output logic              wr_en,
   output logic [MDATAW-1:0] wr_addr,
   output logic [DATAW-1:0]  wr_data,
   output logic              busy,
   output logic              done
);

   localparam int IDXW = FFTSIZ + 1;
   localparam logic [IDXW-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t            state;
   logic [IDXW-1:0]   idx;
   logic [IDXW-1:0]   wr_idx;
   logic [MDATAW-1:0] src_l;
   logic [MDATAW-1:0] dst_l;
   logic              rev_l;
   logic [MDATAW-1:0] rd_off;
   logic [MDATAW-1:0] wr_off;

   // Reverse the point-index bits but keep bit 0 so real/imag words stay adjacent.
   function automatic logic [IDXW-1:0] map_idx(input logic [IDXW-1:0] i, input logic r);
      logic [IDXW-1:0] m;
      m = i;
      if (r) begin
         for (int b = 0; b < FFTSIZ; b++) begin
            m[b+1] = i[FFTSIZ-b];
         end
      end
      return m;
   endfunction

   // Control FSM: latches the move parameters and sequences read, final write and done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         wr_idx <= '0;
         src_l  <= '0;
         dst_l  <= '0;
         rev_l  <= 1'b0;
         rd_en  <= 1'b0;
         wr_en  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         wr_en  <= rd_en;
         wr_idx <= idx;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  idx   <= '0;
                  src_l <= src;
                  dst_l <= dst;
                  rev_l <= rev;
                  rd_en <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               idx <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  state <= FLUSH;
                  rd_en <= 1'b0;
               end
            end
            FLUSH: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               rd_en <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Address generation: sums wrap naturally, addresses forced to zero when idle.
   always_comb begin
      rd_off  = MDATAW'(map_idx(idx, rev_l));
      wr_off  = MDATAW'(wr_idx);
      rd_addr = rd_en ? (src_l + rd_off) : '0;
      wr_addr = wr_en ? (dst_l + wr_off) : '0;
      wr_data = rd_data;
   end

endmodule

// File: tb/tb_fft_bitrev_mover.sv
// tb/tb_fft_bitrev_mover.sv - scoreboard bench for fft_bitrev_mover with a synchronous RAM model
module tb_fft_bitrev_mover;

   logic        clk = 1'b0;
   logic        rst, start, rev;
   logic [7:0]  src, dst;
   logic        rd_en, wr_en, busy, done;
   logic [7:0]  rd_addr, wr_addr;
   logic [15:0] rd_data, wr_data;

   logic [15:0] mem [256];
   logic        pl_we = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [15:0] pl_data = '0;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int exp_rd [$];
   int exp_wa [$];
   int exp_wd [$];
   int revtab [16] = '{0, 1, 8, 9, 4, 5, 12, 13, 2, 3, 10, 11, 6, 7, 14, 15};

   fft_bitrev_mover #(.MDATAW(8), .DATAW(16), .FFTSIZ(3)) dut (
      .clk(clk), .rst(rst), .start(start), .rev(rev), .src(src), .dst(dst),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // synchronous RAM: one-cycle read latency, plus a preload port for the bench
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
      if (pl_we) mem[pl_addr] <= pl_data;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pop expected reads/writes whenever the DUT strobes
   always @(negedge clk) begin
      if (rd_en) begin
         if (exp_rd.size() == 0) chk("unexpected_rd", 1, 0);
         else chk("rd_addr", int'(rd_addr), exp_rd.pop_front());
      end
      if (wr_en) begin
         if (exp_wa.size() == 0) chk("unexpected_wr", 1, 0);
         else begin
            chk("wr_addr", int'(wr_addr), exp_wa.pop_front());
            chk("wr_data", int'(wr_data), exp_wd.pop_front());
         end
      end
      if (done) done_cnt++;
   end

   task automatic write_word(input int a, input int d);
      @(negedge clk);
      pl_we = 1'b1; pl_addr = 8'(a); pl_data = 16'(d);
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic preload(input int base, input int val);
      for (int i = 0; i < 16; i++) write_word((base + i) & 255, val + i);
   endtask

   task automatic push_move(input int s, input int d, input bit r, input int val, input int nrd, input int nwr);
      for (int k = 0; k < nrd; k++) exp_rd.push_back((s + (r ? revtab[k] : k)) & 255);
      for (int k = 0; k < nwr; k++) begin
         exp_wa.push_back((d + k) & 255);
         exp_wd.push_back(val + (r ? revtab[k] : k));
      end
   endtask

   task automatic run_move(input int s, input int d, input bit r, input bit tog, input string nm);
      int cyc, rdc, wrc, bsc;
      cyc = 0; rdc = 0; wrc = 0; bsc = 0;
      @(negedge clk);
      src = 8'(s); dst = 8'(d); rev = r; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (rd_en) rdc++;
         if (wr_en) wrc++;
         if (busy) bsc++;
         if (done) break;
         if (tog) begin
            src = 8'($urandom); dst = 8'($urandom); rev = 1'($urandom);
         end
         if (cyc > 100) begin
            chk({nm, "_timeout"}, 1, 0);
            break;
         end
      end
      chk({nm, "_done_cycle"}, cyc, 18);
      chk({nm, "_rd_cycles"}, rdc, 16);
      chk({nm, "_wr_cycles"}, wrc, 16);
      chk({nm, "_busy_cycles"}, bsc, 17);
      @(negedge clk);
      chk({nm, "_done_pulse_len"}, int'(done), 0);
      chk({nm, "_queues_empty"}, exp_rd.size() + exp_wa.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      int wait_cyc;
      rst = 1'b1; start = 1'b0; rev = 1'b0; src = '0; dst = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rd_en", int'(rd_en), 0);
      chk("reset_wr_en", int'(wr_en), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_rd_addr", int'(rd_addr), 0);
      chk("reset_wr_addr", int'(wr_addr), 0);
      rst = 1'b0;

      // bit-reversed move
      preload(8'h00, 0);
      push_move(8'h00, 8'h40, 1'b1, 0, 16, 16);
      run_move(8'h00, 8'h40, 1'b1, 1'b0, "rev");
      for (int k = 0; k < 16; k++) chk("rev_mem", int'(mem[8'h40 + k]), revtab[k]);

      // same move with inputs toggling during busy
      preload(8'h40, 16'hF000);
      push_move(8'h00, 8'h40, 1'b1, 0, 16, 16);
      run_move(8'h00, 8'h40, 1'b1, 1'b1, "toggle");
      for (int k = 0; k < 16; k++) chk("toggle_mem", int'(mem[8'h40 + k]), revtab[k]);

      // plain copy
      preload(8'h10, 16'h0100);
      push_move(8'h10, 8'h80, 1'b0, 16'h0100, 16, 16);
      run_move(8'h10, 8'h80, 1'b0, 1'b0, "copy");
      for (int k = 0; k < 16; k++) chk("copy_mem", int'(mem[8'h80 + k]), 16'h0100 + k);

      // address wrap on both sides
      preload(8'hF8, 16'h0200);
      push_move(8'hF8, 8'hF4, 1'b0, 16'h0200, 16, 16);
      run_move(8'hF8, 8'hF4, 1'b0, 1'b0, "wrap");
      chk("wrap_mem_f4", int'(mem[8'hF4]), 16'h0200);
      chk("wrap_mem_03", int'(mem[8'h03]), 16'h020F);

      // start held high: exactly two back-to-back moves
      preload(8'h20, 16'h0300);
      push_move(8'h20, 8'hA0, 1'b0, 16'h0300, 16, 16);
      push_move(8'h20, 8'hA0, 1'b0, 16'h0300, 16, 16);
      dc = done_cnt;
      @(negedge clk);
      src = 8'h20; dst = 8'hA0; rev = 1'b0; start = 1'b1;
      wait_cyc = 0;
      while (!done && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      chk("held_first_done", int'(done), 1);
      @(negedge clk);
      chk("held_idle_gap", int'(busy), 0);
      @(negedge clk);
      chk("held_second_busy", int'(busy), 1);
      chk("held_second_rd", int'(rd_addr), 8'h20);
      start = 1'b0;
      for (int p = 0; p < 3; p++) begin
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
      end
      wait_cyc = 0;
      while (!done && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      repeat (6) @(negedge clk);
      chk("held_final_idle", int'(busy), 0);
      chk("held_done_count", done_cnt - dc, 2);
      chk("held_queues_empty", exp_rd.size() + exp_wa.size(), 0);

      // reset in the middle of a move
      for (int k = 0; k < 16; k++) write_word(8'hC0 + k, 16'h00EE);
      preload(8'h30, 16'h0050);
      push_move(8'h30, 8'hC0, 1'b0, 16'h0050, 5, 4);
      dc = done_cnt;
      @(negedge clk);
      src = 8'h30; dst = 8'hC0; rev = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_cyc = 0;
      begin
         int rdn;
         rdn = 0;
         while (rdn < 5 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
            if (rd_en) rdn++;
         end
         chk("abort_reached_5th_rd", rdn, 5);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rd_en", int'(rd_en), 0);
      chk("abort_wr_en", int'(wr_en), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_rd_addr", int'(rd_addr), 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_no_done", done_cnt - dc, 0);
      chk("abort_queues_empty", exp_rd.size() + exp_wa.size(), 0);
      for (int k = 0; k < 16; k++) chk("abort_mem", int'(mem[8'hC0 + k]), (k < 4) ? (16'h0050 + k) : 16'h00EE);

      // fresh move right after reset deasserts
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      push_move(8'h30, 8'hC0, 1'b0, 16'h0050, 16, 16);
      run_move(8'h30, 8'hC0, 1'b0, 1'b0, "post_reset");
      chk("post_reset_mem_last", int'(mem[8'hCF]), 16'h005F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_bitrev_mover.md
FFT_BITREV_MOVER -- requirements
Module: fft_bitrev_mover

Interface
REQ-001 Parameter MDATAW, default 8, data-memory address width.
REQ-002 Parameter DATAW, default 16, data-memory word width.
REQ-003 Parameter FFTSIZ, default 3, log2 of FFT point count N (N = 2^FFTSIZ complex points = 2N words, real/imag interleaved, real at even offset).
REQ-004 Port clk input 1: single clock; all state updates on rising edge.
REQ-005 Port rst input 1: synchronous, active-high reset.
REQ-006 Port start input 1: request a block move; sampled only in IDLE.
REQ-007 Port rev input 1: 1 = read source in bit-reversed point order; 0 = plain copy.
REQ-008 Port src input MDATAW: source base address.
REQ-009 Port dst input MDATAW: destination base address.
REQ-010 Port rd_en output 1: memory read strobe.
REQ-011 Port rd_addr output MDATAW: memory read address.
REQ-012 Port rd_data input DATAW: read data, valid exactly one cycle after rd_en (synchronous RAM).
REQ-013 Port wr_en output 1: memory write strobe.
REQ-014 Port wr_addr output MDATAW: memory write address.
REQ-015 Port wr_data output DATAW: memory write data.
REQ-016 Port busy output 1: high while a move is in progress.
REQ-017 Port done output 1: single-cycle completion pulse.

Function
REQ-018 States SHALL be IDLE, RUN, FLUSH, DONE.
REQ-019 IDLE with start=1 SHALL latch src, dst, rev, clear word index idx (FFTSIZ+1 bits) and go to RUN; start=0 stays IDLE.
REQ-020 In RUN rd_en SHALL be 1 and rd_addr = src_l + map(idx), where map(idx) = {bitrev(idx[FFTSIZ:1]), idx[0]} if rev_l else idx, zero-extended to MDATAW (LSB skipped so real/imag stay adjacent).
REQ-021 idx SHALL increment by one each RUN cycle; when idx = 2N-1 the next state SHALL be FLUSH.
REQ-022 wr_en SHALL equal rd_en delayed one cycle; wr_addr SHALL equal dst_l + (idx delayed one cycle), natural order; wr_data SHALL equal rd_data combinationally.
REQ-023 FLUSH SHALL last one cycle (final write, rd_en=0), then DONE.
REQ-024 DONE SHALL assert done=1 for one cycle, then IDLE; done=0 in all other states.
REQ-025 busy SHALL be 1 in RUN and FLUSH, 0 in IDLE and DONE.
REQ-026 Total: start sampled at edge E0 -> 2N rd_en cycles after E0, 2N wr_en cycles offset by one, done in cycle 2N+2 after E0.
REQ-027 start while not IDLE SHALL be ignored; src/dst/rev changes after E0 SHALL not affect the move in progress.
REQ-028 Address sums SHALL wrap modulo 2^MDATAW, no saturation or flag.
REQ-029 rd_addr and wr_addr SHALL be 0 when respective strobe is 0.
REQ-030 In-place (src = dst) is not supported; result undefined, no detection required.

Reset
REQ-031 rst=1 SHALL force IDLE, idx=0, rd_en=0, wr_en=0, busy=0, done=0, rd_addr=0, wr_addr=0, latched registers 0, on the next edge.
REQ-032 rst mid-move SHALL abort with no further rd_en/wr_en and no done pulse; a start one cycle after rst deasserts SHALL begin a fresh move.
REQ-033 rst SHALL take priority over start on the same edge.

Verification (FFTSIZ=3, MDATAW=8, memory preloaded mem[src+i]=i)
REQ-034 rev=1, src=0x00, dst=0x40, start pulse -> rd_addr sequence 00,01,08,09,04,05,0C,0D,02,03,0A,0B,06,07,0E,0F; mem[0x40..0x4F] = 0,1,8,9,4,5,12,13,2,3,10,11,6,7,14,15; done at cycle 18 after start edge.
REQ-035 rev=0, src=0x10, dst=0x80 -> mem[0x80..0x8F] = mem[0x10..0x1F] unchanged order; 16 wr_en cycles, busy high 17 cycles.
REQ-036 src=0xF8, dst=0xF4, rev=0 -> read addresses F8..FF,00..07 and write addresses F4..FF,00..03 (wrap).
REQ-037 start held high through completion -> second move begins the cycle after DONE returns to IDLE; start pulses during busy produce no extra moves.
REQ-038 rst asserted at 5th rd_en cycle -> next cycle rd_en=wr_en=busy=0, no done; only dst+0..dst+3 written.
REQ-039 src/dst/rev toggled randomly during busy -> results identical to REQ-034.
